// File: rtl/rv_mem_pkg.sv
// Shared types for the RV32I MEM stage: access size/extension modes, writeback
// source select and the memory handshake states.
package rv_mem_pkg;

    typedef enum logic [2:0] {
        AM_B  = 3'b000,
        AM_H  = 3'b001,
        AM_W  = 3'b010,
        AM_BU = 3'b100,
        AM_HU = 3'b101
    } addr_mode_e;

    typedef enum logic [1:0] {
        RS_ALU = 2'b00,
        RS_MEM = 2'b01,
        RS_PC4 = 2'b10
    } result_src_e;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_e;

    // Halfword needs a[0]==0; word and the reserved modes (treated as word) need a[1:0]==0.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] a);
        logic mis;
        case (mode)
            AM_B, AM_BU: mis = 1'b0;
            AM_H, AM_HU: mis = a[0];
            default:     mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Store byte-enable/lane replication and load byte/half extract with sign/zero extend.
// Purely combinational, zero latency, no flow control.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_word_i[7:0];
        case (addr_lo_i)
            2'd1:    ld_byte = ld_word_i[15:8];
            2'd2:    ld_byte = ld_word_i[23:16];
            2'd3:    ld_byte = ld_word_i[31:24];
            default: ld_byte = ld_word_i[7:0];
        endcase
        ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    end

    // mode_i[2] distinguishes the unsigned load variants (BU/HU).
    always_comb begin
        st_be_o   = 4'hF;
        st_data_o = st_data_i;
        ld_data_o = ld_word_i;
        case (mode_i)
            AM_B, AM_BU: begin
                st_be_o   = 4'b0001 << addr_lo_i;
                st_data_o = {4{st_data_i[7:0]}};
                ld_data_o = mode_i[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            AM_H, AM_HU: begin
                st_be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
                ld_data_o = mode_i[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                st_be_o   = 4'hF;
                st_data_o = st_data_i;
                ld_data_o = ld_word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// RV32I MEM stage: data-memory req/ack access, lane alignment, MEM->WB register (1 cycle).
// Stalls upstream while a request is outstanding; MEM_STAGE_MISALIGN_EN enables misalign trapping.
module mem_stage_access
    import rv_mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] PCPlus4M,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic [2:0]       AddrModeM,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             StallM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [WIDTH-1:0] ALUResultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [4:0]       RdW,
    output logic             MisalignW
);

    mem_state_e       state_q, state_d;
    logic             access;
    logic             misalign;
    logic [3:0]       st_be;
    logic [WIDTH-1:0] st_wdata;
    logic [WIDTH-1:0] ld_data;

    assign access = MemWriteM | (ResultSrcM == RS_MEM);

`ifdef MEM_STAGE_MISALIGN_EN
    assign misalign = access & is_misaligned(AddrModeM, ALUResultM[1:0]);
`else
    assign misalign = 1'b0;
`endif

    mem_lane_align u_align (
        .mode_i    (AddrModeM),
        .addr_lo_i (ALUResultM[1:0]),
        .st_data_i (WriteDataM),
        .ld_word_i (dmem_rdata),
        .st_be_o   (st_be),
        .st_data_o (st_wdata),
        .ld_data_o (ld_data)
    );

    assign dmem_addr  = {ALUResultM[WIDTH-1:2], 2'b00};
    assign dmem_wdata = st_wdata;
    assign dmem_be    = MemWriteM ? st_be : 4'hF;
    assign dmem_we    = dmem_req & MemWriteM;

    // Request/stall are suppressed during reset so an abandoned access drops req immediately.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        StallM   = 1'b0;
        if (!rst) begin
            case (state_q)
                MS_IDLE: begin
                    if (access && !misalign) begin
                        dmem_req = 1'b1;
                        if (!dmem_ack) begin
                            StallM  = 1'b1;
                            state_d = MS_WAIT;
                        end
                    end
                end
                MS_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        state_d = MS_IDLE;
                    end else begin
                        StallM = 1'b1;
                    end
                end
                default: state_d = MS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= 5'd0;
            MisalignW  <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            RdW       <= 5'd0;
            MisalignW <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~misalign;
            RdW        <= misalign ? 5'd0 : RdM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= ld_data;
            PCPlus4W   <= PCPlus4M;
            MisalignW  <= misalign;
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: stores, loads, multi-cycle ack, reset abort,
// misaligned halfword and non-memory passthrough.
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  AddrModeM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM, RegWriteW, MisalignW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_access dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .AddrModeM(AddrModeM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW), .MisalignW(MisalignW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic rw, input logic [1:0] rs,
                         input logic mw, input logic [2:0] am);
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = pc4;
        RdM        = rd;
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        AddrModeM  = am;
    endtask

    // Drive a load at the next negedge with same-cycle ack and check the extended result.
    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [2:0] am,
                            input logic [31:0] rdata, input logic [31:0] exp);
        @(negedge clk);
        drive(addr, 32'h0, 32'h0, 5'd5, 1'b1, 2'b01, 1'b0, am);
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(posedge clk); #1;
        chk({tag, "_data"}, ReadDataW, exp);
    endtask

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 3'b010);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, StallM}, 32'h0);
        chk("rst_regwr", {31'h0, RegWriteW}, 32'h0);
        chk("rst_rd", {27'h0, RdW}, 32'h0);
        chk("rst_mis", {31'h0, MisalignW}, 32'h0);
        chk("rst_alu", ALUResultW, 32'h0);

        // SB to 0x103, ack same cycle
        @(negedge clk);
        rst = 1'b0;
        drive(32'h103, 32'h000000AB, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 3'b000);
        dmem_ack = 1'b1;
        #1;
        chk("sb_req", {31'h0, dmem_req}, 32'h1);
        chk("sb_we", {31'h0, dmem_we}, 32'h1);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_be", {28'h0, dmem_be}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_stall", {31'h0, StallM}, 32'h0);

        // SB lane 1, SW full word
        @(negedge clk);
        drive(32'h101, 32'h0000005A, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 3'b000);
        #1;
        chk("sb1_be", {28'h0, dmem_be}, 32'h2);
        @(negedge clk);
        drive(32'h104, 32'h12345678, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 3'b010);
        #1;
        chk("sw_be", {28'h0, dmem_be}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'h12345678);

        // Loads: read enables, extract/extend
        @(negedge clk);
        drive(32'h102, 32'h0, 32'h0, 5'd5, 1'b1, 2'b01, 1'b0, 3'b000);
        dmem_rdata = 32'h00800000;
        #1;
        chk("lb_be", {28'h0, dmem_be}, 32'hF);
        chk("lb_we", {31'h0, dmem_we}, 32'h0);
        @(posedge clk); #1;
        chk("lb_data", ReadDataW, 32'hFFFFFF80);
        chk("lb_regwr", {31'h0, RegWriteW}, 32'h1);
        chk("lb_rd", {27'h0, RdW}, 32'd5);
        chk("lb_src", {30'h0, ResultSrcW}, 32'h1);
        load_chk("lbu", 32'h102, 3'b100, 32'h00800000, 32'h00000080);
        load_chk("lhu", 32'h102, 3'b101, 32'hBEEF0000, 32'h0000BEEF);
        load_chk("lh", 32'h102, 3'b001, 32'hBEEF0000, 32'hFFFFBEEF);
        load_chk("lh_lo", 32'h100, 3'b001, 32'h1234F00D, 32'hFFFFF00D);
        load_chk("lw", 32'h104, 3'b010, 32'h80000001, 32'h80000001);
        load_chk("lrsv", 32'h108, 3'b011, 32'h80000001, 32'h80000001);

        // LW with ack after 3 stalled cycles
        @(negedge clk);
        drive(32'h200, 32'h0, 32'h0, 5'd7, 1'b1, 2'b01, 1'b0, 3'b010);
        dmem_ack = 1'b0;
        dmem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_stall", {31'h0, StallM}, 32'h1);
            chk("wait_req", {31'h0, dmem_req}, 32'h1);
            @(posedge clk); #1;
            chk("wait_bub_rw", {31'h0, RegWriteW}, 32'h0);
            chk("wait_bub_rd", {27'h0, RdW}, 32'h0);
            @(negedge clk);
        end
        dmem_ack = 1'b1;
        #1;
        chk("wait_ack_stall", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("wait_done_rw", {31'h0, RegWriteW}, 32'h1);
        chk("wait_done_rd", {27'h0, RdW}, 32'd7);
        chk("wait_done_data", ReadDataW, 32'hCAFEF00D);

        // Reset while waiting abandons the access
        @(negedge clk);
        drive(32'h300, 32'h0, 32'h0, 5'd9, 1'b1, 2'b01, 1'b0, 3'b010);
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rw_stall", {31'h0, StallM}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rw_req", {31'h0, dmem_req}, 32'h0);
        chk("rw_stall0", {31'h0, StallM}, 32'h0);
        chk("rw_regwr", {31'h0, RegWriteW}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 3'b010);
        #1;
        chk("rw_idle_req", {31'h0, dmem_req}, 32'h0);
        chk("rw_idle_stall", {31'h0, StallM}, 32'h0);

        // Ack without request is ignored
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        chk("stray_ack_stall", {31'h0, StallM}, 32'h0);

        // Misaligned SH
        @(negedge clk);
        drive(32'h101, 32'h00001234, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 3'b001);
        dmem_ack = 1'b1;
        #1;
`ifdef MEM_STAGE_MISALIGN_EN
        chk("mis_req", {31'h0, dmem_req}, 32'h0);
        chk("mis_stall", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("mis_flag", {31'h0, MisalignW}, 32'h1);
        chk("mis_addr", ALUResultW, 32'h101);
        chk("mis_regwr", {31'h0, RegWriteW}, 32'h0);
`else
        chk("mis_req", {31'h0, dmem_req}, 32'h1);
        chk("mis_be", {28'h0, dmem_be}, 32'h3);
        chk("mis_wdata", dmem_wdata, 32'h12341234);
        @(posedge clk); #1;
        chk("mis_flag", {31'h0, MisalignW}, 32'h0);
`endif

        // ADD then JAL back-to-back
        @(negedge clk);
        drive(32'h55, 32'h0, 32'h1004, 5'd3, 1'b1, 2'b00, 1'b0, 3'b010);
        dmem_ack = 1'b0;
        #1;
        chk("add_req", {31'h0, dmem_req}, 32'h0);
        chk("add_stall", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        chk("add_rw", {31'h0, RegWriteW}, 32'h1);
        chk("add_rd", {27'h0, RdW}, 32'd3);
        chk("add_alu", ALUResultW, 32'h55);
        chk("add_src", {30'h0, ResultSrcW}, 32'h0);
        chk("add_mis", {31'h0, MisalignW}, 32'h0);
        @(negedge clk);
        drive(32'h99, 32'h0, 32'h2008, 5'd1, 1'b1, 2'b10, 1'b0, 3'b010);
        #1;
        chk("jal_req", {31'h0, dmem_req}, 32'h0);
        @(posedge clk); #1;
        chk("jal_pc4", PCPlus4W, 32'h2008);
        chk("jal_rd", {27'h0, RdW}, 32'd1);
        chk("jal_src", {30'h0, ResultSrcW}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
